ms_timer_sched: RTL and testbench

Multi-channel millisecond timeout scheduler for the FTDI engine. It shares one periodic tick source and one decrementer among `N_CH` software-visible timeout channels. Commands arm or cancel channels through a valid/ready port. On every tick, a scan state machine walks all channels, decrements the armed counters, and pulses a per-channel expire strobe when a count reaches zero. It sits beside the protocol engines, which use it for latency-timer and watchdog timeouts.

---
 rtl/ms_timer_sched_pkg.sv | 15 +
 rtl/mod_m_counter.sv | 28 ++
 rtl/ms_timer_sched.sv | 126 ++++++++++++
 tb/tb_ms_timer_sched.sv | 269 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/ms_timer_sched_pkg.sv
// Shared state encoding and command constants for the millisecond timeout scheduler.
// No logic; imported by the scheduler top.
package ms_timer_sched_pkg;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    SCAN = 1'b1
  } state_e;

  localparam logic OP_START  = 1'b0;
  localparam logic OP_CANCEL = 1'b1;

  localparam int MAX_N_CH = 16;

endpackage

// File: rtl/mod_m_counter.sv
// Free-running modulo-COUNT counter that produces the scheduler's periodic tick.
// Latency: count_tick is high for one cycle at the end of every COUNT-cycle period.
// Backpressure: none; the tick is free-running and cannot be stalled.
module mod_m_counter #(
  parameter int COUNT = 50_000
) (
  input  logic clk_i,
  input  logic rst_n,
  output logic count_tick
);

  localparam int QW = (COUNT > 1) ? $clog2(COUNT) : 1;

  logic [QW-1:0] q;

  assign count_tick = (q == QW'(COUNT - 1));

  always_ff @(posedge clk_i or negedge rst_n) begin
    if (!rst_n) begin
      q <= '0;
    end else if (count_tick) begin
      q <= '0;
    end else begin
      q <= q + QW'(1);
    end
  end

endmodule

// File: rtl/ms_timer_sched.sv
// Multi-channel tick-based timeout scheduler sharing one decrementer across N_CH channels.
// Latency: channel k is decremented at tick+1+k, its expire pulse appears at tick+2+k.
// Backpressure: cmd_ready_o drops for the N_CH scan cycles that follow each tick.
// Build option MS_TIMER_SCHED_EXT_TICK_EN replaces the internal tick counter with a tick_i input.
module ms_timer_sched
  import ms_timer_sched_pkg::*;
#(
  parameter int COUNT = 50_000,
  parameter int N_CH  = 4,
  parameter int CW    = 16,
  localparam int CHW  = (N_CH > 1) ? $clog2(N_CH) : 1
) (
  input  logic            clk_i,
  input  logic            rst_n,
`ifdef MS_TIMER_SCHED_EXT_TICK_EN
  input  logic            tick_i,
`endif
  input  logic            cmd_valid_i,
  output logic            cmd_ready_o,
  input  logic            cmd_op_i,
  input  logic [CHW-1:0]  cmd_ch_i,
  input  logic [CW-1:0]   cmd_ms_i,
  output logic [N_CH-1:0] active_o,
  output logic [N_CH-1:0] expire_o,
  output logic            tick_o
);

  if (N_CH < 1 || N_CH > MAX_N_CH) begin : g_bad_n_ch
    $error("ms_timer_sched: N_CH out of range");
  end

  logic            tick;
  state_e          state;
  logic [CHW-1:0]  idx;
  logic            pending;
  logic            ready_q;
  logic [N_CH-1:0] active_q;
  logic [N_CH-1:0] expire_q;
  logic [CW-1:0]   cnt [N_CH];
  logic            cmd_fire;
  logic            cmd_ch_ok;

`ifdef MS_TIMER_SCHED_EXT_TICK_EN
  assign tick = tick_i;
`else
  if (COUNT <= N_CH + 2) begin : g_bad_count
    $error("ms_timer_sched: COUNT must exceed N_CH + 2");
  end

  mod_m_counter #(.COUNT(COUNT)) u_tick (
    .clk_i      (clk_i),
    .rst_n      (rst_n),
    .count_tick (tick)
  );
`endif

  // ready_q keeps the port low during reset and for the first cycle after it
  assign cmd_ready_o = ready_q && (state == IDLE);
  assign cmd_fire    = cmd_valid_i && cmd_ready_o;
  assign cmd_ch_ok   = (int'(cmd_ch_i) < N_CH);

  assign active_o = active_q;
  assign expire_o = expire_q;
  assign tick_o   = tick;

  always_ff @(posedge clk_i or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      idx      <= '0;
      pending  <= 1'b0;
      ready_q  <= 1'b0;
      active_q <= '0;
      expire_q <= '0;
      for (int i = 0; i < N_CH; i++) begin
        cnt[i] <= '0;
      end
    end else begin
      ready_q  <= 1'b1;
      expire_q <= '0;
      case (state)
        IDLE: begin
          if (cmd_fire && cmd_ch_ok) begin
            if (cmd_op_i == OP_CANCEL) begin
              active_q[cmd_ch_i] <= 1'b0;
              cnt[cmd_ch_i]      <= '0;
            end else if (cmd_ms_i == '0) begin
              // zero timeout expires immediately instead of arming
              active_q[cmd_ch_i] <= 1'b0;
              cnt[cmd_ch_i]      <= '0;
              expire_q[cmd_ch_i] <= 1'b1;
            end else begin
              active_q[cmd_ch_i] <= 1'b1;
              cnt[cmd_ch_i]      <= cmd_ms_i;
            end
          end
          if (tick || pending) begin
            state   <= SCAN;
            idx     <= '0;
            pending <= 1'b0;
          end
        end
        SCAN: begin
          if (tick) begin
            pending <= 1'b1;
          end
          if (active_q[idx]) begin
            if (cnt[idx] > CW'(1)) begin
              cnt[idx] <= cnt[idx] - CW'(1);
            end else begin
              cnt[idx]      <= '0;
              active_q[idx] <= 1'b0;
              expire_q[idx] <= 1'b1;
            end
          end
          if (idx == CHW'(N_CH - 1)) begin
            state <= IDLE;
          end else begin
            idx <= idx + CHW'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ms_timer_sched.sv
// Randomized and directed bench for ms_timer_sched (COUNT=10, N_CH=4, CW=8) against a cycle-number model.
module tb_ms_timer_sched;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       cmd_valid = 1'b0;
  logic       cmd_op = 1'b0;
  logic [1:0] cmd_ch = '0;
  logic [7:0] cmd_ms = '0;
  logic       cmd_ready_o;
  logic [3:0] active_o;
  logic [3:0] expire_o;
  logic       tick_o;

  int checks = 0;
  int errors = 0;

  // Reference model: n counts clock edges since reset release. Ticks fall on
  // cycles with n%10==9, so channel k is scanned on cycles n>=10 with n%10==k.
  int       n = 0;
  int       m_cnt [4];
  bit [3:0] m_act = '0;
  bit [3:0] m_exp = '0;

  ms_timer_sched #(.COUNT(10), .N_CH(4), .CW(8)) dut (
    .clk_i       (clk),
    .rst_n       (rst_n),
    .cmd_valid_i (cmd_valid),
    .cmd_ready_o (cmd_ready_o),
    .cmd_op_i    (cmd_op),
    .cmd_ch_i    (cmd_ch),
    .cmd_ms_i    (cmd_ms),
    .active_o    (active_o),
    .expire_o    (expire_o),
    .tick_o      (tick_o)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic bit model_ready(input int c);
    return (c >= 1) && !(c >= 10 && (c % 10) <= 3);
  endfunction

  function automatic bit model_tick(input int c);
    return (c % 10) == 9;
  endfunction

  task automatic model_edge();
    int k;
    m_exp = '0;
    if (n >= 10 && (n % 10) <= 3) begin
      k = n % 10;
      if (m_act[k]) begin
        m_cnt[k] = m_cnt[k] - 1;
        if (m_cnt[k] == 0) begin
          m_act[k] = 1'b0;
          m_exp[k] = 1'b1;
        end
      end
    end
    if (cmd_valid && model_ready(n)) begin
      if (cmd_op) begin
        m_act[cmd_ch] = 1'b0;
        m_cnt[cmd_ch] = 0;
      end else if (cmd_ms == 0) begin
        m_act[cmd_ch] = 1'b0;
        m_cnt[cmd_ch] = 0;
        m_exp[cmd_ch] = 1'b1;
      end else begin
        m_act[cmd_ch] = 1'b1;
        m_cnt[cmd_ch] = int'(cmd_ms);
      end
    end
    n++;
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic assert_reset();
    rst_n = 1'b0;
    cmd_valid = 1'b0;
    #1;
  endtask

  task automatic release_reset();
    repeat (2) @(posedge clk);
    #1;
    n = 0;
    m_act = '0;
    m_exp = '0;
    for (int i = 0; i < 4; i++) m_cnt[i] = 0;
    rst_n = 1'b1;
  endtask

  task automatic issue(input bit op, input int ch, input int ms);
    while (!model_ready(n)) step();
    cmd_valid = 1'b1;
    cmd_op = op;
    cmd_ch = 2'(ch);
    cmd_ms = 8'(ms);
    step();
    cmd_valid = 1'b0;
  endtask

  task automatic test_reset();
    assert_reset();
    checks += 4;
    if (cmd_ready_o !== 1'b0) begin errors++; $display("FAIL reset_ready got=%b want=0", cmd_ready_o); end
    if (active_o !== 4'b0000) begin errors++; $display("FAIL reset_active got=%b want=0000", active_o); end
    if (expire_o !== 4'b0000) begin errors++; $display("FAIL reset_expire got=%b want=0000", expire_o); end
    if (tick_o !== 1'b0) begin errors++; $display("FAIL reset_tick got=%b want=0", tick_o); end
    release_reset();
    repeat (14) begin
      step();
      checks += 3;
      if (cmd_ready_o !== ((n <= 9 || n >= 14) ? 1'b1 : 1'b0))
        begin errors++; $display("FAIL post_reset_ready n=%0d got=%b", n, cmd_ready_o); end
      if (active_o !== 4'b0000 || expire_o !== 4'b0000)
        begin errors++; $display("FAIL post_reset_idle n=%0d active=%b expire=%b want 0000/0000", n, active_o, expire_o); end
      if (tick_o !== ((n == 9) ? 1'b1 : 1'b0))
        begin errors++; $display("FAIL post_reset_tick n=%0d got=%b", n, tick_o); end
    end
  endtask

  task automatic test_start();
    logic [3:0] exp_e;
    assert_reset();
    release_reset();
    issue(1'b0, 2, 3);
    checks++;
    if (active_o !== 4'b0100) begin errors++; $display("FAIL start_active got=%b want=0100", active_o); end
    while (n < 40) begin
      step();
      exp_e = (n == 33) ? 4'b0100 : 4'b0000;
      checks += 2;
      if (expire_o !== exp_e) begin errors++; $display("FAIL start_expire n=%0d got=%b want=%b", n, expire_o, exp_e); end
      if (active_o !== m_act || expire_o !== m_exp || cmd_ready_o !== model_ready(n) || tick_o !== model_tick(n))
        begin errors++; $display("FAIL start_model n=%0d active=%b/%b expire=%b/%b ready=%b tick=%b", n, active_o, m_act, expire_o, m_exp, cmd_ready_o, tick_o); end
    end
    checks++;
    if (active_o !== 4'b0000) begin errors++; $display("FAIL start_disarm got=%b want=0000", active_o); end
  endtask

  task automatic test_back_to_back();
    logic [3:0] exp_e;
    assert_reset();
    release_reset();
    issue(1'b0, 0, 1);
    issue(1'b0, 3, 1);
    while (n < 20) begin
      step();
      exp_e = (n == 11) ? 4'b0001 : (n == 14) ? 4'b1000 : 4'b0000;
      checks += 2;
      if (expire_o !== exp_e) begin errors++; $display("FAIL b2b_expire n=%0d got=%b want=%b", n, expire_o, exp_e); end
      if (active_o !== m_act || expire_o !== m_exp || cmd_ready_o !== model_ready(n))
        begin errors++; $display("FAIL b2b_model n=%0d active=%b/%b expire=%b/%b ready=%b", n, active_o, m_act, expire_o, m_exp, cmd_ready_o); end
    end
  endtask

  task automatic test_cancel();
    assert_reset();
    release_reset();
    issue(1'b0, 1, 5);
    while (n < 25) step();
    issue(1'b1, 1, 0);
    checks++;
    if (active_o[1] !== 1'b0) begin errors++; $display("FAIL cancel_active got=%b want=0", active_o[1]); end
    repeat (100) begin
      step();
      checks += 2;
      if (expire_o !== 4'b0000 || active_o !== 4'b0000)
        begin errors++; $display("FAIL cancel_quiet n=%0d active=%b expire=%b want 0000/0000", n, active_o, expire_o); end
      if (active_o !== m_act || expire_o !== m_exp || cmd_ready_o !== model_ready(n))
        begin errors++; $display("FAIL cancel_model n=%0d active=%b/%b expire=%b/%b", n, active_o, m_act, expire_o, m_exp); end
    end
  endtask

  task automatic test_reload();
    logic [3:0] exp_e;
    assert_reset();
    release_reset();
    issue(1'b0, 1, 2);
    while (n < 15) step();
    issue(1'b0, 1, 4);
    while (n < 60) begin
      step();
      exp_e = (n == 52) ? 4'b0010 : 4'b0000;
      checks += 2;
      if (expire_o !== exp_e) begin errors++; $display("FAIL reload_expire n=%0d got=%b want=%b", n, expire_o, exp_e); end
      if (active_o !== m_act || expire_o !== m_exp)
        begin errors++; $display("FAIL reload_model n=%0d active=%b/%b expire=%b/%b", n, active_o, m_act, expire_o, m_exp); end
    end
  endtask

  task automatic test_zero();
    assert_reset();
    release_reset();
    issue(1'b0, 0, 0);
    checks += 2;
    if (expire_o !== 4'b0001) begin errors++; $display("FAIL zero_expire got=%b want=0001", expire_o); end
    if (active_o !== 4'b0000) begin errors++; $display("FAIL zero_active got=%b want=0000", active_o); end
    while (n < 30) begin
      step();
      checks++;
      if (expire_o !== 4'b0000 || active_o[0] !== 1'b0)
        begin errors++; $display("FAIL zero_after n=%0d active=%b expire=%b", n, active_o, expire_o); end
    end
  endtask

  task automatic test_reset_mid_scan();
    assert_reset();
    release_reset();
    issue(1'b0, 0, 2);
    while (n < 20) step();
    checks++;
    if (active_o !== 4'b0001) begin errors++; $display("FAIL midscan_armed got=%b want=0001", active_o); end
    assert_reset();
    checks += 2;
    if (expire_o !== 4'b0000) begin errors++; $display("FAIL midscan_reset_expire got=%b want=0000", expire_o); end
    if (active_o !== 4'b0000) begin errors++; $display("FAIL midscan_reset_active got=%b want=0000", active_o); end
    release_reset();
    repeat (30) begin
      step();
      checks++;
      if (expire_o !== 4'b0000 || active_o !== 4'b0000)
        begin errors++; $display("FAIL midscan_after n=%0d active=%b expire=%b want 0000/0000", n, active_o, expire_o); end
    end
  endtask

  task automatic test_random();
    assert_reset();
    release_reset();
    repeat (400) begin
      cmd_valid = ($urandom_range(0, 2) == 0);
      cmd_op = ($urandom_range(0, 4) == 0);
      cmd_ch = 2'($urandom_range(0, 3));
      cmd_ms = 8'($urandom_range(0, 4));
      step();
      checks++;
      if (active_o !== m_act || expire_o !== m_exp || cmd_ready_o !== model_ready(n) || tick_o !== model_tick(n))
        begin errors++; $display("FAIL random_model n=%0d active=%b/%b expire=%b/%b ready=%b tick=%b", n, active_o, m_act, expire_o, m_exp, cmd_ready_o, tick_o); end
    end
    cmd_valid = 1'b0;
  endtask

  initial begin
    test_reset();
    test_start();
    test_back_to_back();
    test_cancel();
    test_reload();
    test_zero();
    test_reset_mid_scan();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
